// File: rtl/fetch_redirect_ctrl_if.sv
// ID/EX branch inputs and fetch-stage redirect/flush outputs of fetch_redirect_ctrl.
// The controller uses the slave modport; the pipeline side uses master.
interface fetch_redirect_ctrl_if #(
  parameter int PC_W = 32
);
  logic            id_br_valid;
  logic [PC_W-1:0] id_pc;
  logic [PC_W-1:0] id_target;
  logic            load_use;
  logic            ex_res_valid;
  logic            ex_taken;
  logic            is_branch;
  logic [PC_W-1:0] branch_pc;
  logic            is_restore;
  logic            is_stall;
  logic            flush_if_id;
  logic            flush_id_ex;

  modport slave (
    input  id_br_valid, id_pc, id_target, load_use, ex_res_valid, ex_taken,
    output is_branch, branch_pc, is_restore, is_stall, flush_if_id, flush_id_ex
  );

  modport master (
    output id_br_valid, id_pc, id_target, load_use, ex_res_valid, ex_taken,
    input  is_branch, branch_pc, is_restore, is_stall, flush_if_id, flush_id_ex
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: predicts ID branches, tracks one in flight, recovers on mispredict.
// Outputs are combinational (0 latency); FETCH_BHT_EN selects a 2-bit BHT over static predict-taken.
module fetch_redirect_ctrl #(
  parameter int PC_W    = 32,
  parameter int BHT_IDX = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_en_i,
  fetch_redirect_ctrl_if.slave bus,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mp_count_o
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             pend_taken_q, pend_taken_d;
  logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
  logic [PC_W-1:0]  pend_target_q, pend_target_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

  logic             active;
  logic             resolve;
  logic             mispredict;
  logic             correct;
  logic             predict_taken;

  logic             is_branch;
  logic [PC_W-1:0]  branch_pc;
  logic             is_restore;
  logic             is_stall;
  logic             flush_if_id;
  logic             flush_id_ex;

  assign active     = !rst && cpu_en_i;
  assign resolve    = bus.ex_res_valid && (state_q == S_WAIT);
  assign mispredict = resolve && (bus.ex_taken != pend_taken_q);
  assign correct    = resolve && !mispredict;

`ifdef FETCH_BHT_EN
  localparam int BHT_N = 1 << BHT_IDX;

  logic [1:0]         bht_q [BHT_N];
  logic [BHT_IDX-1:0] id_idx;
  logic [BHT_IDX-1:0] pend_idx;
  logic               unused_pend_bits;

  assign id_idx           = bus.id_pc[BHT_IDX+1:2];
  assign pend_idx         = pend_pc_q[BHT_IDX+1:2];
  assign predict_taken    = bht_q[id_idx][1];
  assign unused_pend_bits = ^pend_pc_q;

  // Training uses the registered PC of the resolving branch, not the one in ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (cpu_en_i && resolve) begin
      if (bus.ex_taken && (bht_q[pend_idx] != 2'b11)) begin
        bht_q[pend_idx] <= bht_q[pend_idx] + 2'd1;
      end else if (!bus.ex_taken && (bht_q[pend_idx] != 2'b00)) begin
        bht_q[pend_idx] <= bht_q[pend_idx] - 2'd1;
      end
    end
  end
`else
  logic unused_static;

  assign predict_taken = 1'b1;
  assign unused_static = (^pend_pc_q) ^ (BHT_IDX > 0);
`endif

  always_comb begin
    state_d       = state_q;
    pend_taken_d  = pend_taken_q;
    pend_pc_d     = pend_pc_q;
    pend_target_d = pend_target_q;
    is_branch     = 1'b0;
    branch_pc     = '0;
    is_restore    = 1'b0;
    is_stall      = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;

    // Recovery wins over everything; an ID branch this cycle is wrong-path.
    if (mispredict) begin
      state_d     = S_RUN;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      if (pend_taken_q) begin
        is_restore = 1'b1;
      end else begin
        is_branch = 1'b1;
        branch_pc = pend_target_q;
      end
    end else if (bus.load_use) begin
      is_stall = 1'b1;
      if (correct) begin
        state_d = S_RUN;
      end
    end else if (bus.id_br_valid && ((state_q == S_RUN) || correct)) begin
      state_d       = S_WAIT;
      pend_taken_d  = predict_taken;
      pend_pc_d     = bus.id_pc;
      pend_target_d = bus.id_target;
      if (predict_taken) begin
        is_branch   = 1'b1;
        branch_pc   = bus.id_target;
        flush_if_id = 1'b1;
      end
    end else if (bus.id_br_valid) begin
      is_stall = 1'b1;
    end else if (correct) begin
      state_d = S_RUN;
    end
  end

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (resolve && (br_cnt_q != '1)) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (mispredict && (mp_cnt_q != '1)) begin
      mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      pend_taken_q  <= 1'b0;
      pend_pc_q     <= '0;
      pend_target_q <= '0;
      br_cnt_q      <= '0;
      mp_cnt_q      <= '0;
    end else if (cpu_en_i) begin
      state_q       <= state_d;
      pend_taken_q  <= pend_taken_d;
      pend_pc_q     <= pend_pc_d;
      pend_target_q <= pend_target_d;
      br_cnt_q      <= br_cnt_d;
      mp_cnt_q      <= mp_cnt_d;
    end
  end

  assign bus.is_branch   = active && is_branch;
  assign bus.branch_pc   = active ? branch_pc : '0;
  assign bus.is_restore  = active && is_restore;
  assign bus.is_stall    = active && is_stall;
  assign bus.flush_if_id = active && flush_if_id;
  assign bus.flush_id_ex = active && flush_id_ex;
  assign br_count_o      = br_cnt_q;
  assign mp_count_o      = mp_cnt_q;

  a_one_redirect: assert property (@(posedge clk) disable iff (rst)
    $onehot0({bus.is_branch, bus.is_restore, bus.is_stall}));

  a_flush_order: assert property (@(posedge clk) disable iff (rst)
    bus.flush_id_ex |-> bus.flush_if_id);

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios plus random traffic against a rule-level model.
// Counters are narrowed so saturation is reachable in a short run.
module tb_fetch_redirect_ctrl;
  localparam int PC_W    = 32;
  localparam int BHT_IDX = 4;
  localparam int CNT_W   = 6;
  localparam int MAXC    = (1 << CNT_W) - 1;
  localparam int VW      = PC_W + 5 + 2 * CNT_W;
  typedef logic [VW-1:0] vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_en;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  fetch_redirect_ctrl_if #(.PC_W(PC_W)) bus ();

  fetch_redirect_ctrl #(
    .PC_W   (PC_W),
    .BHT_IDX(BHT_IDX),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_en_i  (cpu_en),
    .bus       (bus),
    .br_count_o(br_count),
    .mp_count_o(mp_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model: the one in-flight branch, counters as plain ints, BHT as an int array.
  bit              m_pend  = 1'b0;
  bit              m_taken = 1'b0;
  logic [PC_W-1:0] m_pc    = '0;
  logic [PC_W-1:0] m_tgt   = '0;
  int              m_br    = 0;
  int              m_mp    = 0;
  int              m_bht [1 << BHT_IDX];

  function automatic bit model_predict(input logic [PC_W-1:0] pc);
`ifdef FETCH_BHT_EN
    return m_bht[int'(pc[BHT_IDX+1:2])] >= 2;
`else
    return (pc !== pc) || 1'b1;
`endif
  endfunction

  function automatic vec_t model_expect();
    bit              br = 1'b0, rs = 1'b0, st = 1'b0, f1 = 1'b0, f2 = 1'b0;
    logic [PC_W-1:0] pc = '0;
    bit              res, mis;
    res = bus.ex_res_valid && m_pend;
    mis = res && (bus.ex_taken != m_taken);
    if (!rst && cpu_en) begin
      if (mis) begin
        f1 = 1'b1;
        f2 = 1'b1;
        if (m_taken) rs = 1'b1;
        else begin
          br = 1'b1;
          pc = m_tgt;
        end
      end else if (bus.load_use) begin
        st = 1'b1;
      end else if (bus.id_br_valid && (!m_pend || res)) begin
        if (model_predict(bus.id_pc)) begin
          br = 1'b1;
          pc = bus.id_target;
          f1 = 1'b1;
        end
      end else if (bus.id_br_valid) begin
        st = 1'b1;
      end
    end
    return {br, pc, rs, st, f1, f2, CNT_W'(m_br), CNT_W'(m_mp)};
  endfunction

  function automatic void model_commit();
    bit res, mis, p;
    if (rst) begin
      m_pend = 1'b0;
      m_br   = 0;
      m_mp   = 0;
      for (int i = 0; i < (1 << BHT_IDX); i++) m_bht[i] = 1;
      return;
    end
    if (!cpu_en) return;
    res = bus.ex_res_valid && m_pend;
    mis = res && (bus.ex_taken != m_taken);
    p   = model_predict(bus.id_pc);
    if (res) begin
      int k;
      k = int'(m_pc[BHT_IDX+1:2]);
      m_br = (m_br < MAXC) ? m_br + 1 : MAXC;
      m_bht[k] = bus.ex_taken ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3)
                              : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
    end
    if (mis) begin
      m_mp   = (m_mp < MAXC) ? m_mp + 1 : MAXC;
      m_pend = 1'b0;
    end else if (bus.load_use) begin
      if (res) m_pend = 1'b0;
    end else if (bus.id_br_valid && (!m_pend || res)) begin
      m_pend  = 1'b1;
      m_taken = p;
      m_pc    = bus.id_pc;
      m_tgt   = bus.id_target;
    end else if (!bus.id_br_valid && res) begin
      m_pend = 1'b0;
    end
  endfunction

  function automatic vec_t dut_vec();
    return {bus.is_branch, bus.branch_pc, bus.is_restore, bus.is_stall,
            bus.flush_if_id, bus.flush_id_ex, br_count, mp_count};
  endfunction

  task automatic drive(input bit br, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                       input bit lu, input bit rv, input bit tk);
    bus.id_br_valid  = br;
    bus.id_pc        = pc;
    bus.id_target    = tgt;
    bus.load_use     = lu;
    bus.ex_res_valid = rv;
    bus.ex_taken     = tk;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic settle();
    for (int k = 0; k < 4 && m_pend; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, m_taken);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    vec_t got, exp;
    rst    = 1'b1;
    cpu_en = 1'b1;
    drive(1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      got = dut_vec();
      checks++;
      if (got !== '0) $display("FAIL reset_outputs c%0d got=%h exp=0", i, got);
      else passed++;
      tick();
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    #1;
    got = dut_vec();
    exp = model_expect();
    checks++;
    if (got !== '0 || exp !== '0) $display("FAIL reset_idle got=%h model=%h exp=0", got, exp);
    else passed++;
    tick();
  endtask

`ifndef FETCH_BHT_EN
  task automatic test_static_predict();
    vec_t got;
    drive(1'b1, 32'h100, 32'h40, 1'b0, 1'b0, 1'b0);
    #1;
    got = dut_vec();
    checks++;
    if (got !== {1'b1, 32'h40, 4'b0010, CNT_W'(0), CNT_W'(0)})
      $display("FAIL static_predict got=%h", got);
    else passed++;
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    got = dut_vec();
    checks++;
    if (got !== {1'b0, 32'h0, 4'b1011, CNT_W'(0), CNT_W'(0)})
      $display("FAIL static_restore got=%h", got);
    else passed++;
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (br_count !== CNT_W'(1) || mp_count !== CNT_W'(1))
      $display("FAIL static_counts got br=%0d mp=%0d exp br=1 mp=1", br_count, mp_count);
    else passed++;
  endtask
`else
  task automatic test_bht_learn();
    vec_t got, exp;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 32'h10, 32'h80, 1'b0, 1'b0, 1'b0);
      #1;
      got = dut_vec();
      exp = model_expect();
      checks++;
      if (got !== exp || got[VW-1] !== (r == 2 ? 1'b1 : 1'b0) && r != 1)
        $display("FAIL bht_predict r%0d got=%h exp=%h", r, got, exp);
      else passed++;
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
      #1;
      got = dut_vec();
      exp = model_expect();
      checks++;
      if (got !== exp || (r == 0 && (bus.is_branch !== 1'b1 || bus.branch_pc !== 32'h80)))
        $display("FAIL bht_resolve r%0d got=%h exp=%h", r, got, exp);
      else passed++;
      tick();
    end
  endtask
`endif

  task automatic test_wait_stall();
    vec_t got, exp;
    settle();
    drive(1'b1, 32'h204, 32'h300, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h208, 32'h400, 1'b0, 1'b0, 1'b0);
    #1;
    got = dut_vec();
    exp = model_expect();
    checks++;
    if (got !== exp || bus.is_stall !== 1'b1) $display("FAIL wait_stall got=%h exp=%h", got, exp);
    else passed++;
    tick();
    drive(1'b1, 32'h208, 32'h400, 1'b0, 1'b1, m_taken);
    #1;
    got = dut_vec();
    exp = model_expect();
    checks++;
    if (got !== exp || bus.is_stall !== 1'b0) $display("FAIL wait_accept got=%h exp=%h", got, exp);
    else passed++;
    tick();
    settle();
  endtask

  task automatic test_mispredict_combo();
    vec_t got, exp;
    drive(1'b1, 32'h30c, 32'h500, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h310, 32'h600, 1'b1, 1'b1, !m_taken);
    #1;
    got = dut_vec();
    exp = model_expect();
    checks++;
    if (got !== exp || bus.is_stall !== 1'b0 || bus.flush_id_ex !== 1'b1)
      $display("FAIL combo_recover got=%h exp=%h", got, exp);
    else passed++;
    tick();
    drive(1'b1, 32'h314, 32'h700, 1'b0, 1'b0, 1'b0);
    #1;
    got = dut_vec();
    exp = model_expect();
    checks++;
    if (got !== exp || bus.is_stall !== 1'b0) $display("FAIL combo_run got=%h exp=%h", got, exp);
    else passed++;
    tick();
    settle();
  endtask

  task automatic test_cpu_en();
    vec_t got, exp;
    drive(1'b1, 32'h400, 32'h800, 1'b0, 1'b0, 1'b0);
    tick();
    cpu_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'b1, 1'($urandom));
      #1;
      got = dut_vec();
      exp = model_expect();
      checks++;
      if (got !== exp || got[VW-1:2*CNT_W] !== '0) $display("FAIL cpu_en_off c%0d got=%h exp=%h", i, got, exp);
      else passed++;
      tick();
    end
    cpu_en = 1'b1;
    drive(1'b1, 32'h404, 32'h900, 1'b0, 1'b0, 1'b0);
    #1;
    got = dut_vec();
    exp = model_expect();
    checks++;
    if (got !== exp || bus.is_stall !== 1'b1) $display("FAIL cpu_en_held got=%h exp=%h", got, exp);
    else passed++;
    tick();
    settle();
  endtask

  task automatic test_saturation();
    vec_t got, exp;
    int   bad = 0;
    for (int n = 0; n < MAXC + 4; n++) begin
      drive(1'b1, {$urandom_range(0, 255), 2'b00}, $urandom, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b1, !m_taken);
      #1;
      got = dut_vec();
      exp = model_expect();
      checks++;
      if (got !== exp) begin
        if (bad < 5) $display("FAIL sat_mispredict n%0d got=%h exp=%h", n, got, exp);
        bad++;
      end else passed++;
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (mp_count !== CNT_W'(MAXC) || br_count !== CNT_W'(MAXC))
      $display("FAIL sat_hold got mp=%0d br=%0d exp=%0d", mp_count, br_count, MAXC);
    else passed++;
  endtask

  task automatic test_random();
    vec_t got, exp;
    int   bad = 0;
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 49) == 0);
      cpu_en = ($urandom_range(0, 9) != 0);
      drive($urandom_range(0, 1) == 1, {$urandom_range(0, 3), 24'h0, $urandom_range(0, 63), 2'b00},
            $urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1);
      #1;
      got = dut_vec();
      exp = model_expect();
      checks++;
      if (got !== exp) begin
        if (bad < 8) $display("FAIL random c%0d got=%h exp=%h", i, got, exp);
        bad++;
      end else passed++;
      tick();
    end
    rst    = 1'b0;
    cpu_en = 1'b1;
  endtask

  initial begin
    rst    = 1'b1;
    cpu_en = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    test_reset();
`ifndef FETCH_BHT_EN
    test_static_predict();
`else
    test_bht_learn();
`endif
    test_wait_stall();
    test_mispredict_combo();
    test_cpu_en();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
